// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush controller for the five-stage pipeline.
// It merges four hazard sources into one per-stage hold vector. In priority
// order these are flush, MEM bus wait, EX multi-cycle op and ID load-use.
// The multi-cycle latency and the MEM wait are tracked by two small FSMs
// that run concurrently. A saturating counter records the cycles in which
// any stage is held.
module pipe_stall_ctrl #(
    parameter int STALL_W     = 6,
    parameter int CNT_W       = 6,
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              ex_mc_start,
    input  logic [CNT_W-1:0]  ex_mc_cycles,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [STALL_W-1:0] ctrl_stall,
    output logic              ctrl_flush,
    output logic [31:0]       ctrl_new_pc,
    output logic              mc_done,
    output logic              mem_err,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    // Wait counter is wide enough for the largest legal timeout (2^16-1).
    localparam int WCNT_W = 16;
    localparam logic [WCNT_W-1:0] TIMEOUT = WCNT_W'(MEM_TIMEOUT);

    // Hold vector with the lowest n stages (PC upward) held.
    function automatic logic [STALL_W-1:0] low_ones(input int n);
        logic [STALL_W-1:0] r;
        for (int i = 0; i < STALL_W; i++) begin
            r[i] = (i < n);
        end
        return r;
    endfunction

    // ID holds PC..ID/EX, EX adds EX/MEM, MEM adds MEM/WB.
    localparam logic [STALL_W-1:0] PAT_ID  = low_ones(3);
    localparam logic [STALL_W-1:0] PAT_EX  = low_ones(4);
    localparam logic [STALL_W-1:0] PAT_MEM = low_ones(5);

    typedef enum logic {MC_IDLE, MC_BUSY} mc_state_t;
    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

    mc_state_t         mc_state, mc_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              ex_stall, mc_done_c;

    mem_state_t        mem_state, mem_next;
    logic [WCNT_W-1:0] wcnt, wcnt_next;
    logic              mem_stall, mem_err_c;

    logic [PERF_W-1:0] perf_q;

    // State registers for both sub-FSMs and their counters.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the clock edge. A blocking assignment
    // here would let one register see another's new value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_state  <= MC_IDLE;
            cnt       <= '0;
            mem_state <= MEM_IDLE;
            wcnt      <= '0;
        end else begin
            mc_state  <= mc_next;
            cnt       <= cnt_next;
            mem_state <= mem_next;
            wcnt      <= wcnt_next;
        end
    end

    // Multi-cycle EX tracker: N-1 stall cycles, then a one-cycle done pulse.
    // NOTE: every output of a combinational block gets a default first. A path
    // that leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        mc_next   = mc_state;
        cnt_next  = cnt;
        ex_stall  = 1'b0;
        mc_done_c = 1'b0;
        if (flush_req) begin
            // A redirect abandons the op; its result is never reported.
            mc_next  = MC_IDLE;
            cnt_next = '0;
        end else begin
            case (mc_state)
                MC_IDLE: begin
                    if (ex_mc_start) begin
                        if (ex_mc_cycles >= CNT_W'(2)) begin
                            ex_stall = 1'b1;
                            cnt_next = ex_mc_cycles - CNT_W'(2);
                            mc_next  = MC_BUSY;
                        end else begin
                            mc_done_c = 1'b1;
                        end
                    end
                end
                MC_BUSY: begin
                    // A new start while busy is ignored. The count keeps
                    // running even if a MEM stall covers this EX stall.
                    if (cnt != '0) begin
                        ex_stall = 1'b1;
                        cnt_next = cnt - CNT_W'(1);
                    end else begin
                        mc_done_c = 1'b1;
                        mc_next   = MC_IDLE;
                    end
                end
                default: begin
                    mc_next  = MC_IDLE;
                    cnt_next = '0;
                end
            endcase
        end
    end

    // MEM bus-wait tracker with a forced release after MEM_TIMEOUT cycles.
    always_comb begin
        mem_next  = mem_state;
        wcnt_next = wcnt;
        mem_stall = 1'b0;
        mem_err_c = 1'b0;
        if (flush_req) begin
            mem_next  = MEM_IDLE;
            wcnt_next = '0;
        end else begin
            case (mem_state)
                MEM_IDLE: begin
                    if (mem_req && !mem_ack) begin
                        mem_stall = 1'b1;
                        mem_next  = MEM_WAIT;
                        wcnt_next = WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_req || mem_ack) begin
                        // The request was withdrawn or acknowledged.
                        // Release this cycle.
                        mem_next  = MEM_IDLE;
                        wcnt_next = '0;
                    end else if (wcnt == TIMEOUT) begin
                        mem_err_c = 1'b1;
                        mem_next  = MEM_IDLE;
                        wcnt_next = '0;
                    end else begin
                        mem_stall = 1'b1;
                        wcnt_next = wcnt + WCNT_W'(1);
                    end
                end
                default: begin
                    mem_next  = MEM_IDLE;
                    wcnt_next = '0;
                end
            endcase
        end
    end

    // Priority merge into the visible controls. Everything is forced to zero
    // while reset is held, so inputs have no effect during reset.
    always_comb begin
        ctrl_stall  = '0;
        ctrl_flush  = 1'b0;
        ctrl_new_pc = '0;
        mc_done     = 1'b0;
        mem_err     = 1'b0;
        if (rst) begin
            if (flush_req) begin
                ctrl_flush  = 1'b1;
                ctrl_new_pc = flush_pc;
            end else if (mem_stall) begin
                ctrl_stall = PAT_MEM;
            end else if (ex_stall) begin
                ctrl_stall = PAT_EX;
            end else if (stallreq_id) begin
                ctrl_stall = PAT_ID;
            end
            mc_done = mc_done_c;
            mem_err = mem_err_c;
        end
    end

    // Saturating count of cycles in which any stage is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if ((ctrl_stall != '0) && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign perf_stall_cnt = perf_q;

endmodule
